// File: rtl/out_shift_if.sv
// Parallel-side handshake and serial pin bundle for the 74HC595-style transmitter.
// The master drives the word and request; the slave (transmitter) drives status and pins.
interface out_shift_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] data_in;
  logic              load;
  logic              ready;
  logic              done;
  logic              sdo;
  logic              sclk;
  logic              rclk;

  modport master (
    output data_in, load,
    input  ready, done, sdo, sclk, rclk
  );

  modport slave (
    input  data_in, load,
    output ready, done, sdo, sclk, rclk
  );
endinterface

// File: rtl/out_shift_tx.sv
// Serialises one parallel word per request into a 74HC595-style shift/latch register,
// MSB first, then strobes the latch and pulses done for one cycle.
module out_shift_tx #(
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 2
) (
  input  logic       clk,
  input  logic       rst,
  out_shift_if.slave bus
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT_LO,
    SHIFT_HI,
    LATCH
  } state_t;

  state_t            state, state_next;
  logic [DIV_W-1:0]  div_cnt, div_cnt_next;
  logic [BIT_W-1:0]  bit_idx, bit_idx_next;
  logic [DATA_W-1:0] shreg, shreg_next, shreg_shifted;
  logic              sdo_q, sdo_next;
  logic              done_q, done_next;
  logic              ready_q, sclk_q, rclk_q;
  logic              phase_end;

  assign phase_end     = (div_cnt == DIV_LAST);
  // The word is shifted left so the next bit to present is always the MSB.
  assign shreg_shifted = shreg << 1;

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_next   = state;
    div_cnt_next = div_cnt;
    bit_idx_next = bit_idx;
    shreg_next   = shreg;
    sdo_next     = sdo_q;
    done_next    = 1'b0;

    unique case (state)
      IDLE: begin
        if (bus.load) begin
          shreg_next   = bus.data_in;
          sdo_next     = bus.data_in[DATA_W-1];
          bit_idx_next = BIT_LAST;
          div_cnt_next = '0;
          state_next   = SHIFT_LO;
        end
      end

      SHIFT_LO: begin
        if (phase_end) begin
          div_cnt_next = '0;
          state_next   = SHIFT_HI;
        end else begin
          div_cnt_next = div_cnt + 1'b1;
        end
      end

      SHIFT_HI: begin
        if (phase_end) begin
          div_cnt_next = '0;
          if (bit_idx != '0) begin
            // sdo only moves on the edge that drops sclk, centring it on the next rise.
            bit_idx_next = bit_idx - 1'b1;
            shreg_next   = shreg_shifted;
            sdo_next     = shreg_shifted[DATA_W-1];
            state_next   = SHIFT_LO;
          end else begin
            state_next   = LATCH;
          end
        end else begin
          div_cnt_next = div_cnt + 1'b1;
        end
      end

      LATCH: begin
        if (phase_end) begin
          div_cnt_next = '0;
          done_next    = 1'b1;
          state_next   = IDLE;
        end else begin
          div_cnt_next = div_cnt + 1'b1;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      div_cnt <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      sdo_q   <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
      sclk_q  <= 1'b0;
      rclk_q  <= 1'b0;
    end else begin
      state   <= state_next;
      div_cnt <= div_cnt_next;
      bit_idx <= bit_idx_next;
      shreg   <= shreg_next;
      sdo_q   <= sdo_next;
      done_q  <= done_next;
      // Pin-facing strobes are registered from the next state to stay glitch-free.
      ready_q <= (state_next == IDLE);
      sclk_q  <= (state_next == SHIFT_HI);
      rclk_q  <= (state_next == LATCH);
    end
  end

  assign bus.ready = ready_q;
  assign bus.done  = done_q;
  assign bus.sdo   = sdo_q;
  assign bus.sclk  = sclk_q;
  assign bus.rclk  = rclk_q;

endmodule
